alu_cmd_sequencer: RTL

- Initiator side of the ALU operand/instruction interface. Accepts one ALU command at a time over a valid/ready request port.
- Drives bus_A, bus_B and instruction into the ALU and holds them stable for a fixed number of cycles. Then captures the ALU result and Z/N/C/V flags.
- Returns result and flags over a valid/ready response port.
- Sits between the CPU control path (or a test harness) and the ALU. Also supports result chaining, illegal-opcode rejection and operation counters.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_cmd_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and sequencer state type
package alu_pkg;

  localparam logic [4:0] LD   = 5'h01;
  localparam logic [4:0] ADD  = 5'h03;
  localparam logic [4:0] SUB  = 5'h04;
  localparam logic [4:0] ANDD = 5'h05;
  localparam logic [4:0] ORR  = 5'h06;
  localparam logic [4:0] XORR = 5'h07;
  localparam logic [4:0] NOTT = 5'h08;
  localparam logic [4:0] SL   = 5'h09;
  localparam logic [4:0] SR   = 5'h0A;

  localparam int Z_BIT = 3;
  localparam int N_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } seq_state_t;

  // Opcodes the ALU understands; everything else is rejected without touching the ALU
  function automatic logic is_legal_op(input logic [4:0] op);
    case (op)
      LD, ADD, SUB, ANDD, ORR, XORR, NOTT, SL, SR: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - drives one ALU command at a time and returns its result and flags
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_chain,
  output logic [31:0]      alu_bus_A,
  output logic [31:0]      alu_bus_B,
  output logic [4:0]       alu_instruction,
  input  logic [31:0]      alu_out_bus,
  input  logic             alu_Z,
  input  logic             alu_N,
  input  logic             alu_C,
  input  logic             alu_V,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic              w_accept;
  logic              w_legal;
  logic              w_capture;
  logic [31:0]       w_eff_a;
  logic [3:0]        w_alu_flags;

  logic [3:0]        r_wait;
  logic [31:0]       r_bus_a;
  logic [31:0]       r_bus_b;
  logic [4:0]        r_instr;
  logic [31:0]       r_last;
  logic [31:0]       r_rsp_data;
  logic [3:0]        r_rsp_flags;
  logic              r_rsp_err;
  logic [CNT_W-1:0]  r_op_count;
  logic [CNT_W-1:0]  r_err_count;

  assign w_legal = is_legal_op(cmd_op);
  assign w_eff_a = cmd_chain ? r_last : cmd_a;

  // Pack the ALU flag wires into the {Z,N,C,V} response layout
  always_comb begin
    w_alu_flags        = '0;
    w_alu_flags[Z_BIT] = alu_Z;
    w_alu_flags[N_BIT] = alu_N;
    w_alu_flags[C_BIT] = alu_C;
    w_alu_flags[V_BIT] = alu_V;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode plus the accept/capture strobes that steer the datapath
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_next_state = w_legal ? S_EXEC : S_RESP;
        end
      end
      S_EXEC: begin
        if (r_wait == 4'd0) begin
          w_capture    = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);

  // ALU operand/instruction registers and the latency countdown; operands only move on a legal accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_a <= '0;
      r_bus_b <= '0;
      r_instr <= '0;
      r_wait  <= '0;
    end else if (w_accept && w_legal) begin
      r_bus_a <= w_eff_a;
      r_bus_b <= cmd_b;
      r_instr <= cmd_op;
      r_wait  <= LAT;
    end else if (r_state == S_EXEC && r_wait != 4'd0) begin
      r_wait <= r_wait - 4'd1;
    end
  end

  // Response registers: illegal commands answer immediately with an error, legal ones at capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b1;
    end else if (w_capture) begin
      r_rsp_data  <= alu_out_bus;
      r_rsp_flags <= w_alu_flags;
      r_rsp_err   <= 1'b0;
    end
  end

  // Chaining source: only completed legal operations update it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_last <= '0;
    else if (w_capture) r_last <= alu_out_bus;
  end

  // Wrapping statistics counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_count  <= '0;
      r_err_count <= '0;
    end else begin
      if (w_capture)             r_op_count  <= r_op_count + 1'b1;
      if (w_accept && !w_legal)  r_err_count <= r_err_count + 1'b1;
    end
  end

  assign alu_bus_A       = r_bus_a;
  assign alu_bus_B       = r_bus_b;
  assign alu_instruction = r_instr;
  assign rsp_data        = r_rsp_data;
  assign rsp_flags       = r_rsp_flags;
  assign rsp_err         = r_rsp_err;
  assign op_count        = r_op_count;
  assign err_count       = r_err_count;

endmodule
